// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and sizing helpers for the instruction fetch unit.
package riscv_ifu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Counter must hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return 32'($clog2(depth) + 1);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Pipelined read bus between the fetch unit (master) and instruction memory.
interface instruction_fetch_unit_if;
  import riscv_ifu_pkg::*;

  logic [XLEN-1:0]    m_address;
  logic               m_read;
  logic               m_waitrequest;
  logic [INSTR_W-1:0] m_readdata;
  logic               m_readdatavalid;

  modport master (
    output m_address, m_read,
    input  m_waitrequest, m_readdata, m_readdatavalid
  );

  modport slave (
    input  m_address, m_read,
    output m_waitrequest, m_readdata, m_readdatavalid
  );
endinterface

// File: rtl/instruction_fetch_unit_fifo.sv
// Prefetch FIFO with flush, occupancy count and a registered head entry.
module ifu_fifo
  import riscv_ifu_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  fetch_entry_t               i_push_data,
  input  logic                       i_pop,
  output fetch_entry_t               o_head,
  output logic                       o_valid,
  output logic [cnt_width(DEPTH)-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  fetch_entry_t     r_head;
  logic             r_valid;

  logic             w_pop, w_push;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  fetch_entry_t     w_head_nxt;

  assign w_pop        = i_pop && r_valid && !i_flush;
  assign w_push       = i_push && !i_flush;
  assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
  assign w_count_nxt  = i_flush ? '0 : (r_count + CNT_W'(w_push) - CNT_W'(w_pop));

  // Next head: the word being pushed when the FIFO would otherwise run dry.
  always_comb begin
    w_head_nxt = r_head;
    if (w_count_nxt != '0) begin
      if ((r_count - CNT_W'(w_pop)) == '0) w_head_nxt = i_push_data;
      else                                 w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '{pc: RESET_PC, instr: '0};
    end else begin
      r_rd_ptr <= i_flush ? '0 : w_rd_ptr_nxt;
      r_wr_ptr <= i_flush ? '0 : (r_wr_ptr + PTR_W'(w_push));
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      r_head   <= w_head_nxt;
    end
  end

  assign o_head  = r_head;
  assign o_valid = r_valid;
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch master: issue, response tracking, redirect and prefetch buffer.
// Optional performance counters are enabled with IFU_PERF_CNT_EN.
module instruction_fetch_unit
  import riscv_ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  instruction_fetch_unit_if.master m_bus,
  input  logic                     i_redirect,
  input  logic [XLEN-1:0]          i_redirect_pc,
  output logic [INSTR_W-1:0]       o_instr,
  output logic [XLEN-1:0]          o_pc,
  output logic                     o_valid,
  input  logic                     i_ready
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]              o_starve_cycles,
  output logic [31:0]              o_fetch_count
`endif
);

  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic {S_RESET, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [XLEN-1:0]  r_fetch_pc, w_fetch_pc_nxt;
  logic [XLEN-1:0]  r_resp_pc, w_resp_pc_nxt;
  logic [CNT_W-1:0] r_outstanding, w_outstanding_nxt;
  logic [CNT_W-1:0] r_drop, w_drop_nxt;
  logic [CNT_W-1:0] w_fifo_count;
  logic [SUM_W-1:0] w_reserved;
  logic [XLEN-1:0]  w_target;
  logic             w_read, w_accept, w_resp, w_push;
  logic             w_fifo_valid;
  fetch_entry_t     w_push_data, w_head;

  assign w_target   = i_redirect_pc & ~32'h3;
  assign w_reserved = SUM_W'(r_outstanding) + SUM_W'(w_fifo_count);

  // Next-state, issue gating and counter updates.
  always_comb begin
    w_state_nxt       = r_state;
    w_read            = 1'b0;
    w_accept          = 1'b0;
    w_resp            = 1'b0;
    w_push            = 1'b0;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_resp_pc_nxt     = r_resp_pc;
    w_outstanding_nxt = r_outstanding;
    w_drop_nxt        = r_drop;
    w_push_data       = '{pc: r_resp_pc, instr: m_bus.m_readdata};

    case (r_state)
      S_RESET: w_state_nxt = S_RUN;
      S_RUN:   w_read = (w_reserved < SUM_W'(FIFO_DEPTH)) &&
                        (r_outstanding < CNT_W'(MAX_OUTSTANDING)) && !i_redirect;
      default: w_state_nxt = S_RESET;
    endcase

    w_accept = w_read && !m_bus.m_waitrequest;
    // Strays with nothing outstanding (e.g. across a reset) are ignored.
    w_resp   = m_bus.m_readdatavalid && (r_outstanding != '0);
    w_push   = w_resp && (r_drop == '0) && !i_redirect;

    w_outstanding_nxt = r_outstanding + CNT_W'(w_accept) - CNT_W'(w_resp);
    if (w_accept) w_fetch_pc_nxt = r_fetch_pc + 32'd4;
    if (w_push)   w_resp_pc_nxt  = r_resp_pc + 32'd4;
    if (w_resp && (r_drop != '0)) w_drop_nxt = r_drop - CNT_W'(1);

    if (i_redirect) begin
      w_fetch_pc_nxt = w_target;
      w_resp_pc_nxt  = w_target;
      w_drop_nxt     = w_outstanding_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RESET;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_resp_pc     <= w_resp_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drop        <= w_drop_nxt;
    end
  end

  assign m_bus.m_address = r_fetch_pc;
  assign m_bus.m_read    = w_read;

  ifu_fifo #(
    .DEPTH    (FIFO_DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (i_redirect),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (i_ready),
    .o_head      (w_head),
    .o_valid     (w_fifo_valid),
    .o_count     (w_fifo_count)
  );

  assign o_instr = w_head.instr;
  assign o_pc    = w_head.pc;
  assign o_valid = w_fifo_valid;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_starve_cycles, r_fetch_count;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cycles <= '0;
      r_fetch_count   <= '0;
    end else begin
      if (i_ready && !w_fifo_valid && (r_starve_cycles != '1))
        r_starve_cycles <= r_starve_cycles + 32'd1;
      if (w_accept && (r_fetch_count != '1))
        r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign o_starve_cycles = r_starve_cycles;
  assign o_fetch_count   = r_fetch_count;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed table, corner sequences, random run.
module tb_instruction_fetch_unit;
  import riscv_ifu_pkg::*;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic [31:0] o_instr, o_pc;
  logic        o_valid;
  logic        i_ready = 1'b0;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] o_starve_cycles, o_fetch_count;
`endif

  always #5 clk = ~clk;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(
    .RESET_PC(RPC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .m_bus(bus),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_instr(o_instr), .o_pc(o_pc), .o_valid(o_valid), .i_ready(i_ready)
`ifdef IFU_PERF_CNT_EN
    , .o_starve_cycles(o_starve_cycles), .o_fetch_count(o_fetch_count)
`endif
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct {
    bit w; bit rdy; bit redir; logic [31:0] rpc;
    bit e_read; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int since_rst = 0;
  int lat = 1;
  int n_acc = 0;
  bit hold = 0;
  bit stray = 0;
  req_t pend[$];
  ent_t buf_q[$];
  logic [31:0] m_fetch_pc;
  logic        s_read, s_valid;
  logic [31:0] s_addr, s_pc, s_instr, s_fc;
  vec_t vecs [15];

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input bit w, input bit rdy, input bit redir, input logic [31:0] rpc,
                      input bit e_read, input logic [31:0] e_addr, input bit e_valid, input logic [31:0] e_pc);
    vecs[i].w = w; vecs[i].rdy = rdy; vecs[i].redir = redir; vecs[i].rpc = rpc;
    vecs[i].e_read = e_read; vecs[i].e_addr = e_addr; vecs[i].e_valid = e_valid; vecs[i].e_pc = e_pc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.m_waitrequest = 1'b0; bus.m_readdatavalid = 1'b0; bus.m_readdata = '0;
    i_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pend.delete(); buf_q.delete();
    m_fetch_pc = RPC;
    since_rst = 0;
  endtask

  // One clock: drive inputs (memory model supplies responses), check against the model, advance.
  task automatic step(input bit w, input bit rdy, input bit redir, input logic [31:0] rpc);
    bit from_q, exp_read;
    int due;
    req_t r;
    ent_t e;
    from_q = 0;
    bus.m_waitrequest = w; i_ready = rdy; i_redirect = redir; i_redirect_pc = rpc;
    bus.m_readdatavalid = 1'b0; bus.m_readdata = 32'h0BAD_0BAD;
    if (!hold && pend.size() > 0 && pend[0].due <= cyc) begin
      from_q = 1;
      bus.m_readdatavalid = 1'b1;
      bus.m_readdata = memw(pend[0].addr);
    end else if (stray) begin
      bus.m_readdatavalid = 1'b1;
      bus.m_readdata = 32'hBAD0_0001;
    end
    #1;
    s_read = bus.m_read; s_addr = bus.m_address;
    s_valid = o_valid; s_pc = o_pc; s_instr = o_instr;
`ifdef IFU_PERF_CNT_EN
    s_fc = o_fetch_count;
`else
    s_fc = '0;
`endif
    exp_read = (since_rst >= 1) && (pend.size() + buf_q.size() < DEPTH) && (pend.size() < MAXO) && !redir;
    chk("m_read", 32'(s_read), 32'(exp_read));
    if (exp_read) chk("m_address", s_addr, m_fetch_pc);
    chk("o_valid", 32'(s_valid), 32'(buf_q.size() != 0));
    if (s_valid && buf_q.size() != 0) begin
      chk("o_pc", s_pc, buf_q[0].pc);
      chk("o_instr", s_instr, buf_q[0].instr);
    end
    @(posedge clk); #1;
    if (s_valid && rdy && !redir && buf_q.size() > 0) buf_q.delete(0);
    if (from_q) begin
      r = pend.pop_front();
      if (!r.stale && !redir) begin
        e.pc = r.addr; e.instr = memw(r.addr);
        buf_q.push_back(e);
      end
    end
    if (s_read && !w) begin
      due = cyc + lat;
      if (pend.size() > 0 && pend[pend.size()-1].due >= due) due = pend[pend.size()-1].due + 1;
      r.addr = s_addr; r.due = due; r.stale = 0;
      pend.push_back(r);
      m_fetch_pc = m_fetch_pc + 32'd4;
      n_acc++;
    end
    if (redir) begin
      buf_q.delete();
      foreach (pend[i]) pend[i].stale = 1;
      m_fetch_pc = rpc & ~32'h3;
    end
    cyc++; since_rst++;
  endtask

  initial begin
    int acc0;
    bit found;
    logic [31:0] fc0;

    // Startup stream, a 3-cycle stall on 0x8, then a redirect while 0x18 is stalled.
    setv(0,  0,1,0,0,          0,32'h0,  0,32'h0);
    setv(1,  0,1,0,0,          1,32'h0,  0,32'h0);
    setv(2,  0,1,0,0,          1,32'h4,  0,32'h0);
    setv(3,  1,1,0,0,          1,32'h8,  1,32'h0);
    setv(4,  1,1,0,0,          1,32'h8,  1,32'h4);
    setv(5,  1,1,0,0,          1,32'h8,  0,32'h0);
    setv(6,  0,1,0,0,          1,32'h8,  0,32'h0);
    setv(7,  0,1,0,0,          1,32'hC,  0,32'h0);
    setv(8,  0,1,0,0,          1,32'h10, 1,32'h8);
    setv(9,  0,1,0,0,          1,32'h14, 1,32'hC);
    setv(10, 1,1,0,0,          1,32'h18, 1,32'h10);
    setv(11, 1,1,1,32'h103,    0,32'h18, 1,32'h14);
    setv(12, 0,1,0,0,          1,32'h100,0,32'h0);
    setv(13, 0,1,0,0,          1,32'h104,0,32'h0);
    setv(14, 0,1,0,0,          1,32'h108,1,32'h100);

    do_reset();
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'h0);
    chk("rst_o_instr", o_instr, 32'h0);
    chk("rst_o_pc", o_pc, RPC);
    chk("rst_m_read", 32'(bus.m_read), 32'h0);
    chk("rst_m_address", bus.m_address, RPC);

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].w, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
      chk($sformatf("vec%0d_read", i), 32'(s_read), 32'(vecs[i].e_read));
      chk($sformatf("vec%0d_addr", i), s_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) chk($sformatf("vec%0d_pc", i), s_pc, vecs[i].e_pc);
    end

    // Decode stalls for 10 cycles: only the free space gets fetched.
    acc0 = n_acc;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    chk("stall_read_off", 32'(s_read), 32'h0);
    chk("stall_accepts", 32'(n_acc - acc0), 32'd2);
    chk("stall_head", s_pc, 32'h104);
    step(0, 1, 0, 0);
    chk("resume_head", s_pc, 32'h104);
    for (int i = 0; i < 11; i++) step(0, 1, 0, 0);

    // Redirect with two reads outstanding and 0x10/0x14 buffered.
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
    hold = 1;
    step(1, 0, 1, 32'h10);
    acc0 = n_acc;
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    chk("fill_read_off", 32'(s_read), 32'h0);
    chk("fill_accepts", 32'(n_acc - acc0), 32'd4);
    hold = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    hold = 1;
    step(0, 0, 1, 32'h103);
    chk("redir_head_valid", 32'(s_valid), 32'h1);
    chk("redir_head_pc", s_pc, 32'h10);
    hold = 0;
    step(0, 1, 0, 0);
    chk("post_redir_valid", 32'(s_valid), 32'h0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(0, 1, 0, 0);
      if (s_valid) begin
        found = 1;
        chk("redir_first_pc", s_pc, 32'h100);
      end
    end
    if (!found) chk("redir_timeout", 32'h0, 32'h1);

    // Address wrap at the top of the address space.
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 32'hFFFF_FFFC);
    step(0, 1, 0, 0);
    chk("wrap_read0", 32'(s_read), 32'h1);
    chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    fc0 = s_fc;
    step(0, 1, 0, 0);
    chk("wrap_addr1", s_addr, 32'h0000_0000);
`ifdef IFU_PERF_CNT_EN
    chk("fetch_count_inc1", s_fc, fc0 + 32'd1);
    step(0, 1, 0, 0);
    chk("fetch_count_inc2", s_fc, fc0 + 32'd2);
`endif

    // Random traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      lat = int'($urandom_range(1, 4));
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 3, $urandom());
    end
    lat = 1;

    // Reset mid-stream, then a stray response while nothing is outstanding.
    do_reset();
    stray = 1;
    step(0, 1, 0, 0);
    stray = 0;
    step(0, 1, 0, 0);
    chk("stray_ignored", 32'(s_valid), 32'h0);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      step(0, 1, 0, 0);
      if (s_valid) begin
        found = 1;
        chk("post_rst_pc", s_pc, RPC);
        chk("post_rst_instr", s_instr, memw(RPC));
      end
    end
    if (!found) chk("post_rst_timeout", 32'h0, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch-side master for the instruction memory.
- Issues word addresses over a pipelined read interface and honours waitrequest from the memory.
- Buffers returned words with their PC in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing the buffer and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- FIFO_DEPTH, 4: prefetch entries; must be a power of two and at least 2.
- MAX_OUTSTANDING, 4: maximum accepted-but-unanswered reads; must be ≤ FIFO_DEPTH.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- o_m_address  out  32  fetch address; always word aligned.
- o_m_read  out  1  read request.
- i_m_waitrequest  in  1  memory stall; a request is accepted when o_m_read && !i_m_waitrequest.
- i_m_readdata  in  32  returned instruction word.
- i_m_readdatavalid  in  1  response strobe; responses arrive in request order.
- i_redirect  in  1  redirect pulse from execute.
- i_redirect_pc  in  32  redirect target; bits [1:0] are ignored.
- o_instr  out  32  instruction at the FIFO head.
- o_pc  out  32  PC of o_instr.
- o_valid  out  1  head entry valid.
- i_ready  in  1  decode accepts the head entry.

Behaviour:
- Reset (cycle after rst sampled high):
  - o_m_read=0, o_m_address=RESET_PC, o_valid=0, o_instr=0, o_pc=RESET_PC.
  - Internal state: fetch_pc=resp_pc=RESET_PC, FIFO empty, outstanding=0, drop=0.
  - rst mid-operation: all pending responses are forgotten; any later readdatavalid while drop=0 and outstanding=0 is ignored.
- Issue:
  - o_m_read=1 when (outstanding + fifo_count) < FIFO_DEPTH, outstanding < MAX_OUTSTANDING, and no redirect is being applied this cycle.
  - o_m_address = fetch_pc.
  - While i_m_waitrequest=1, address and read are held stable unless a redirect occurs.
  - On acceptance: fetch_pc += 4 (wraps modulo 2^32) and outstanding++.
- Response:
  - Each readdatavalid decrements outstanding.
  - If drop > 0: decrement drop and discard the word.
  - Otherwise: push {resp_pc, readdata} into the FIFO and resp_pc += 4.
  - Acceptance and response in the same cycle leave outstanding unchanged.
- Output:
  - o_valid = FIFO not empty; o_instr/o_pc come from the head, registered.
  - Pop on o_valid && i_ready.
  - A word returned in cycle N is visible at o_valid in N+1.
  - Full back-to-back throughput: 1 instruction per cycle when waitrequest=0 and i_ready=1.
- Full FIFO: the issue gate reserves space for every outstanding read, so a push never overflows. Push and pop in the same cycle on a full FIFO is legal.
- Redirect (i_redirect=1 in cycle N):
  - Flush the FIFO; o_valid=0 in N+1. A same-cycle pop is ignored.
  - fetch_pc = resp_pc = {i_redirect_pc[31:2],2'b00}.
  - drop = outstanding after this cycle's acceptance/response, all of which are discarded.
  - An unaccepted stalled request is withdrawn; the new address is presented from N+1.
  - Back-to-back redirects: the last one wins.
- FSM: RESET → RUN. Redirect handling is a single-cycle action within RUN, not a separate state.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - o_starve_cycles [31:0]: counts cycles with i_ready=1 && o_valid=0.
  - o_fetch_count [31:0]: counts accepted requests.
  - Both clear on rst and saturate at all-ones.
- When undefined, the ports and counters are absent and the behaviour is otherwise identical.

Decomposition:
- Package riscv_ifu_pkg: XLEN=32, INSTR_W=32, default RESET_PC, fifo entry typedef {pc[31:0], instr[31:0]}, and counter width function clog2(FIFO_DEPTH)+1.
- Sub-module ifu_fifo: synchronous FIFO with a flush input, count output, and registered head.
- Top level holds the issue logic, outstanding/drop counters and the redirect logic.

Test Plan:
- Reset, then waitrequest=0, 1-cycle memory, i_ready=1 → addresses 0x0,0x4,0x8…; o_pc 0x0,0x4,0x8 on consecutive cycles, starting 2 cycles after the first request.
- Assert waitrequest for 3 cycles on address 0x8 → o_m_address holds 0x8 with read=1 for all 3 cycles; exactly one entry with o_pc=0x8, no duplicate.
- i_ready=0 for 10 cycles → at most 4 accepted reads beyond the consumed ones; o_m_read drops to 0; no entry is lost when i_ready returns.
- Redirect to 0x103 with 2 reads outstanding and the FIFO holding 0x10,0x14 → next o_pc is 0x100; the 2 stale words are discarded and are never presented.
- Redirect while a request at 0x20 is stalled → address 0x20 is withdrawn; the next cycle presents the target address.
- Starting at fetch_pc=0xFFFF_FFFC → next address is 0x0000_0000. With IFU_PERF_CNT_EN, o_fetch_count increments by 1 per acceptance.
